// File: rtl/wb_slave_pkg.sv
// rtl/wb_slave_pkg.sv - shared types, mode constants and sizing helpers for wb_slave_mem
package wb_slave_pkg;

  // Widest supported data bus; response entries carry data at this width.
  localparam int RESP_DW  = 64;

  localparam int MODE_MEM = 0;
  localparam int MODE_CNT = 1;

  typedef struct packed {
    logic               valid;
    logic               err;
    logic [RESP_DW-1:0] data;
  } resp_t;

  function automatic int WB_SEL_W(input int dw);
    return dw / 8;
  endfunction

  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++) begin
      if ((64'd1 << r) >= 64'(v)) return r;
    end
    return 32;
  endfunction

endpackage

// File: rtl/wb_slave_mem_resp_pipe.sv
// rtl/wb_slave_mem_resp_pipe.sv - response delay line for wb_slave_mem
//   clk, rst_n     : clock, async active-low reset
//   flush_i        : drop every in-flight response (valid bits cleared next edge)
//   in_*_i         : response entering stage 0 on this edge
//   out_*_o        : response leaving the last stage; out_data_o holds between responses
module wb_resp_pipe
  import wb_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic                  in_err_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  output logic                  out_err_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  resp_t stage_q [LATENCY];
  resp_t stage_d [LATENCY];

  always_comb begin
    stage_d[0]       = '0;
    stage_d[0].valid = in_valid_i;
    stage_d[0].err   = in_err_i;
    stage_d[0].data  = RESP_DW'(in_data_i);
    for (int i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
    if (flush_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_d[i].valid = 1'b0;
        stage_d[i].err   = 1'b0;
      end
    end
    // The last stage is the bus data register: it only loads on a real response.
    if (!stage_d[LATENCY-1].valid) stage_d[LATENCY-1].data = stage_q[LATENCY-1].data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign out_valid_o = stage_q[LATENCY-1].valid;
  assign out_err_o   = stage_q[LATENCY-1].err;
  assign out_data_o  = stage_q[LATENCY-1].data[DATA_WIDTH-1:0];

  if (DATA_WIDTH < RESP_DW) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^stage_q[LATENCY-1].data[RESP_DW-1:DATA_WIDTH];
  end

endmodule

// File: rtl/wb_slave_mem.sv
// rtl/wb_slave_mem.sv - Wishbone B4 pipelined slave memory with latency, stall and error control
//   clk, rst_n              : clock, async active-low reset
//   wb_cyc_i/stb_i/we_i     : bus cycle, strobe, write enable
//   wb_adr_i/sel_i/dat_i    : byte address, byte lanes, write data
//   wb_dat_o/ack_o/err_o    : response data, normal / error termination
//   wb_stall_o              : request not accepted this cycle
//   outstanding_o           : accepted but unanswered requests
module wb_slave_mem
  import wb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH_WORDS     = 1024,
  parameter int ACK_LATENCY     = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_EVERY     = 0,
  parameter int MODE            = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_stall_o,
  output logic [3:0]              outstanding_o
);

  localparam int SEL_W = WB_SEL_W(DATA_WIDTH);
  localparam int SHIFT = clog2(SEL_W);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam logic [15:0] INJ_LAST = 16'(STALL_EVERY - 1);

  logic                  stall_q, stall_d, inject_d;
  logic [3:0]            out_q, out_d;
  logic [15:0]           inj_q, inj_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic                  accept, oor, retire, flush;
  logic                  rsp_valid, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data, rsp_in_data, rd_data;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_adr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  assign flush      = !wb_cyc_i;
  assign accept     = wb_cyc_i & wb_stb_i & !stall_q;
  assign idx        = wb_adr_i >> SHIFT;
  assign oor        = (MODE == MODE_MEM) && (idx >= DEPTH_A);
  assign rd_data    = mem_q[idx[IDX_W-1:0]];
  assign retire     = rsp_valid && (out_q != 4'd0);
  assign unused_adr = ^wb_adr_i[SHIFT-1:0];

  always_comb begin
    // Free-running injection phase; stall_q tracks the phase of the cycle it is visible in.
    inj_d = '0;
    if (STALL_EVERY != 0 && inj_q != INJ_LAST) inj_d = inj_q + 16'd1;
    inject_d = (STALL_EVERY != 0) && (inj_d == INJ_LAST);

    out_d = out_q;
    if (flush) out_d = '0;
    else if (accept && !retire) out_d = out_q + 4'd1;
    else if (!accept && retire) out_d = out_q - 4'd1;

    stall_d = (out_d >= MAX_OUT) | inject_d;

    pat_d = pat_q;
    if (MODE == MODE_CNT && accept && !wb_we_i) pat_d = pat_q + DATA_WIDTH'(1);

    if (MODE == MODE_CNT) rsp_in_data = wb_we_i ? '0 : pat_q;
    else                  rsp_in_data = (wb_we_i || oor) ? '0 : rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      out_q   <= '0;
      inj_q   <= '0;
      pat_q   <= '0;
    end else begin
      stall_q <= stall_d;
      out_q   <= out_d;
      inj_q   <= inj_d;
      pat_q   <= pat_d;
    end
  end

  // Storage is not reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (MODE == MODE_MEM && accept && wb_we_i && !oor) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (wb_sel_i[b]) mem_q[idx[IDX_W-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
      end
    end
  end

  wb_resp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (ACK_LATENCY)
  ) u_resp_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (accept),
    .in_err_i    (oor),
    .in_data_i   (rsp_in_data),
    .out_valid_o (rsp_valid),
    .out_err_o   (rsp_err),
    .out_data_o  (rsp_data)
  );

  assign wb_ack_o      = rsp_valid & !rsp_err;
  assign wb_err_o      = rsp_valid & rsp_err;
  assign wb_dat_o      = rsp_data;
  assign wb_stall_o    = stall_q;
  assign outstanding_o = out_q;

endmodule
